// File: rtl/multicycle_controller.sv
// multicycle_controller: FETCH/DECODE/EXEC/MEM/WB control FSM driving IR, PC, ALU-src, dmem and regfile enables.
// Latency: 4 cycles per IMM/REG/STORE, 5 per LOAD with zero-wait memories; each wait cycle adds one.
// Backpressure: imem_req / dmem strobes held until the matching ready; MEM gives up after MEM_TIMEOUT cycles.
// Optional: define CTRL_PERF_CNT_EN to add cycle_cnt / retire_cnt performance counters.
module multicycle_controller #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_WIDTH   = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instruction,
   input  logic        imem_ready,
   input  logic        dmem_ready,
   output logic        imem_req,
   output logic        ir_write,
   output logic        pc_write,
   output logic        alu_src_imm,
   output logic        dmem_read,
   output logic        dmem_write,
   output logic        reg_write,
   output logic        mem_to_reg,
   output logic        illegal,
   output logic        mem_fault,
   output logic [2:0]  state
`ifdef CTRL_PERF_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0] cycle_cnt,
   output logic [CNT_WIDTH-1:0] retire_cnt
`endif
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   typedef enum logic [1:0] {C_IMM, C_LOAD, C_STORE, C_REG} cls_t;

   // Last wait cycle allowed in MEM; the counter holds the number of wait cycles already spent.
   localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

   if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255 || CNT_WIDTH < 1) begin : g_bad_param
      $error("multicycle_controller: MEM_TIMEOUT must be 1..255 and CNT_WIDTH >= 1");
   end

   state_t     r_state, w_next;
   cls_t       r_cls, w_dec_cls;
   logic       w_dec_ok;
   logic       r_rd_zero;
   logic       r_illegal;
   logic       r_mem_fault;
   logic [7:0] r_tmo;
   logic       w_tmo_hit;
   logic       w_imem_req, w_ir_write, w_pc_write, w_alu_src_imm;
   logic       w_dmem_read, w_dmem_write, w_reg_write, w_mem_to_reg;
   logic       w_unused_ir;

   // Only opcode and rd fields are interpreted here; the rest belongs to the datapath.
   assign w_unused_ir = ^instruction[31:12];

   assign w_tmo_hit = (r_state == S_MEM) && !dmem_ready && (r_tmo == TMO_LAST);

   // Opcode classification of the current IR contents
   always_comb begin
      w_dec_cls = C_IMM;
      w_dec_ok  = 1'b1;
      case (instruction[6:0])
         7'b0010011: w_dec_cls = C_IMM;
         7'b0000011: w_dec_cls = C_LOAD;
         7'b0100011: w_dec_cls = C_STORE;
         7'b0110011: w_dec_cls = C_REG;
         default:    w_dec_ok  = 1'b0;
      endcase
   end

   // Next-state and control strobes
   always_comb begin
      w_next        = r_state;
      w_imem_req    = 1'b0;
      w_ir_write    = 1'b0;
      w_pc_write    = 1'b0;
      w_alu_src_imm = 1'b0;
      w_dmem_read   = 1'b0;
      w_dmem_write  = 1'b0;
      w_reg_write   = 1'b0;
      w_mem_to_reg  = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_imem_req = 1'b1;
            if (imem_ready) begin
               w_ir_write = 1'b1;
               w_next     = S_DECODE;
            end
         end
         S_DECODE: w_next = w_dec_ok ? S_EXEC : S_HALT;
         S_EXEC: begin
            w_alu_src_imm = (r_cls != C_REG);
            w_next        = (r_cls == C_LOAD || r_cls == C_STORE) ? S_MEM : S_WB;
         end
         S_MEM: begin
            w_alu_src_imm = 1'b1;
            w_dmem_read   = (r_cls == C_LOAD);
            w_dmem_write  = (r_cls == C_STORE);
            if (dmem_ready) begin
               if (r_cls == C_STORE) begin
                  w_pc_write = 1'b1;
                  w_next     = S_FETCH;
               end else begin
                  w_next = S_WB;
               end
            end else if (w_tmo_hit) begin
               w_next = S_HALT;
            end
         end
         S_WB: begin
            w_pc_write   = 1'b1;
            w_reg_write  = !r_rd_zero;
            w_mem_to_reg = (r_cls == C_LOAD);
            w_next       = S_FETCH;
         end
         S_HALT:  w_next = S_HALT;
         default: w_next = S_FETCH;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_FETCH;
      else     r_state <= w_next;
   end

   // Decoded class/rd latch, sticky error flags and MEM wait counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cls       <= C_IMM;
         r_rd_zero   <= 1'b0;
         r_illegal   <= 1'b0;
         r_mem_fault <= 1'b0;
         r_tmo       <= 8'd0;
      end else begin
         if (r_state == S_DECODE) begin
            r_cls     <= w_dec_cls;
            r_rd_zero <= (instruction[11:7] == 5'd0);
            if (!w_dec_ok) r_illegal <= 1'b1;
         end
         if (r_state == S_EXEC)                      r_tmo <= 8'd0;
         else if (r_state == S_MEM && !dmem_ready)   r_tmo <= r_tmo + 8'd1;
         if (w_tmo_hit) r_mem_fault <= 1'b1;
      end
   end

   // Strobes are forced low while reset is held so no partial pulse escapes.
   assign imem_req    = w_imem_req    & ~rst;
   assign ir_write    = w_ir_write    & ~rst;
   assign pc_write    = w_pc_write    & ~rst;
   assign alu_src_imm = w_alu_src_imm & ~rst;
   assign dmem_read   = w_dmem_read   & ~rst;
   assign dmem_write  = w_dmem_write  & ~rst;
   assign reg_write   = w_reg_write   & ~rst;
   assign mem_to_reg  = w_mem_to_reg  & ~rst;
   assign illegal     = r_illegal;
   assign mem_fault   = r_mem_fault;
   assign state       = r_state;

`ifdef CTRL_PERF_CNT_EN
   logic [CNT_WIDTH-1:0] r_cycle_cnt, r_retire_cnt;

   // Free-running cycle count (stops in HALT) and retired-instruction count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cycle_cnt  <= '0;
         r_retire_cnt <= '0;
      end else begin
         if (r_state != S_HALT) r_cycle_cnt  <= r_cycle_cnt + CNT_WIDTH'(1);
         if (pc_write)          r_retire_cnt <= r_retire_cnt + CNT_WIDTH'(1);
      end
   end

   assign cycle_cnt  = r_cycle_cnt;
   assign retire_cnt = r_retire_cnt;
`endif

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle control FSM for the lab core; sequences fetch, decode, immediate/ALU execute, data-memory access and register writeback.
- Supports OP-IMM (7'b0010011), LOAD (7'b0000011), STORE (7'b0100011), OP (7'b0110011).
- Drives the IR, PC, ALU-source mux, data memory and regfile write enables.
- Sits between the instruction register and the datapath; the immediate generator feeds the ALU when alu_src_imm=1.

Parameters:
- MEM_TIMEOUT, 16: max cycles waiting for dmem_ready in MEM before fault; legal range 1..255.
- CNT_WIDTH, 32: width of performance counters (optional feature only).

Ports:
- clk  input  1  core clock, rising edge
- rst  input  1  asynchronous, active-high reset
- instruction  input  32  current IR contents
- imem_ready  input  1  instruction memory response valid
- dmem_ready  input  1  data memory access complete
- imem_req  output  1  instruction fetch request
- ir_write  output  1  load IR this cycle
- pc_write  output  1  PC <= PC+4 this cycle
- alu_src_imm  output  1  1 = ALU operand B from sign-extended immediate
- dmem_read  output  1  data memory read strobe
- dmem_write  output  1  data memory write strobe
- reg_write  output  1  regfile write enable
- mem_to_reg  output  1  1 = writeback data from memory
- illegal  output  1  sticky: unsupported opcode decoded
- mem_fault  output  1  sticky: dmem_ready timeout
- state  output  3  current state, for debug

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Codes 6–7 are unreachable and go to FETCH on the next clock.
- Reset:
  - Asynchronous; state=FETCH, illegal=0, mem_fault=0, timeout counter=0.
  - All control outputs are 0 while rst=1, including imem_req.
  - Reset mid-instruction aborts the instruction; no pc_write or reg_write pulse is emitted.
- FETCH:
  - imem_req=1 until imem_ready.
  - Cycle with imem_ready=1: ir_write=1 (combinational on imem_ready), next=DECODE.
- DECODE:
  - One cycle. Classifies instruction[6:0] into a registered class (IMM, LOAD, STORE, REG).
  - Latches rd_zero = (instruction[11:7]==0).
  - Later IR changes are ignored until the next DECODE.
  - Unsupported opcode: illegal<=1, next=HALT. Otherwise next=EXEC.
- EXEC:
  - One cycle. alu_src_imm=1 for IMM, LOAD and STORE; 0 for REG.
  - IMM/REG go to WB; LOAD/STORE go to MEM.
- MEM:
  - alu_src_imm=1. dmem_read=1 (LOAD) or dmem_write=1 (STORE), held until dmem_ready.
  - Timeout counter clears on entry and increments each cycle without dmem_ready.
  - Counter reaching MEM_TIMEOUT with dmem_ready=0: mem_fault<=1, strobes drop, next=HALT.
  - dmem_ready in the same cycle as the timeout: the access completes; no fault.
  - STORE complete: pc_write=1 that cycle, next=FETCH.
  - LOAD complete: next=WB.
- WB:
  - One cycle. pc_write=1.
  - reg_write=1 unless rd_zero. mem_to_reg=1 for LOAD.
  - next=FETCH.
- HALT:
  - Terminal until rst. All strobes 0; illegal/mem_fault hold.
- Ignored inputs: imem_ready outside FETCH; dmem_ready outside MEM.
- Latency with zero-wait memories: IMM/REG/STORE take 4 cycles per instruction; LOAD takes 5.
- Each wait cycle on imem_ready or dmem_ready adds one cycle.
- pc_write pulses exactly once per retired instruction.

Optional Feature:
- Macro: CTRL_PERF_CNT_EN.
- Defined:
  - Adds outputs cycle_cnt[CNT_WIDTH-1:0] and retire_cnt[CNT_WIDTH-1:0].
  - Both reset to 0 asynchronously.
  - cycle_cnt increments every clock not in HALT.
  - retire_cnt increments on each pc_write.
  - Both wrap modulo 2^CNT_WIDTH.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- Reset, imem_ready=1 constant, IR=32'h00500093 (addi x1,x0,5): states 0,1,2,4,0. ir_write in cycle 0; pc_write and reg_write in cycle 3; alu_src_imm=1 in cycle 2.
- IR=32'h0000A103 (lw x2,0(x1)), dmem_ready delayed 3 cycles: dmem_read high 4 cycles. WB asserts reg_write=1 and mem_to_reg=1; total 8 cycles.
- IR=32'h0020A223 (sw), dmem_ready=0 for 16 cycles: mem_fault=1, state=5, dmem_write drops, no pc_write; remains in HALT.
- IR=32'hFFFFFFFF: DECODE→HALT, illegal=1, imem_req=0 thereafter. rst pulse clears illegal and returns to FETCH.
- IR=32'h00500013 (addi x0,x0,5): WB has pc_write=1, reg_write=0. Assert rst during MEM of a load: outputs 0 immediately, state=0, no reg_write.
- With CTRL_PERF_CNT_EN and CNT_WIDTH=4: 20 back-to-back addi give retire_cnt=20 mod 16=4, cycle_cnt=80 mod 16=0.
